// File: rtl/counter_timestamp_fifo_if.sv
// Bus bundle between the timestamp FIFO and its surroundings: counter/event input side,
// valid/ready head output side, and status/clear.
interface counter_timestamp_fifo_if #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned WRAP_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_WIDTH   = $clog2(DEPTH)
);
  logic [COUNT_WIDTH-1:0] count;
  logic                   event_valid;
  logic [TAG_WIDTH-1:0]   event_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] out_count;
  logic [WRAP_WIDTH-1:0]  out_wraps;
  logic [TAG_WIDTH-1:0]   out_tag;
  logic [PTR_WIDTH:0]     level;
  logic [15:0]            dropped;
  logic                   overflow;
  logic                   clear;

  // Driver side: upstream counter, event source and host readout.
  modport master (
    output count, event_valid, event_tag, out_ready, clear,
    input  out_valid, out_count, out_wraps, out_tag, level, dropped, overflow
  );

  // The timestamp FIFO itself.
  modport slave (
    input  count, event_valid, event_tag, out_ready, clear,
    output out_valid, out_count, out_wraps, out_tag, level, dropped, overflow
  );
endinterface

// File: rtl/counter_timestamp_fifo.sv
// Samples the upstream wrap counter on event strobes, extends it with a wrap epoch and
// buffers {count, epoch, tag} in a first-word-fall-through FIFO with drop accounting.
module counter_timestamp_fifo #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned MAX_COUNT   = 10,
  parameter int unsigned WRAP_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_WIDTH   = $clog2(DEPTH)
) (
  input logic                     clk,
  input logic                     rst,
  counter_timestamp_fifo_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] LP_MAX   = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [PTR_WIDTH:0]     LP_DEPTH = (PTR_WIDTH + 1)'(DEPTH);

  logic [COUNT_WIDTH-1:0] r_prev_count;
  logic [WRAP_WIDTH-1:0]  r_wraps;
  logic [COUNT_WIDTH-1:0] r_mem_count [DEPTH];
  logic [WRAP_WIDTH-1:0]  r_mem_wraps [DEPTH];
  logic [TAG_WIDTH-1:0]   r_mem_tag   [DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [PTR_WIDTH:0]     r_level;
  logic [15:0]            r_dropped;
  logic                   r_overflow;

  logic                   w_count_zero;
  logic                   w_wrap_now;
  logic                   w_restart;
  logic [WRAP_WIDTH-1:0]  w_epoch;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  assign w_count_zero = (bus.count == '0);
  assign w_wrap_now   = w_count_zero && (r_prev_count == LP_MAX);
  // A jump to zero from anywhere but MAX or 0 means the upstream counter was reset.
  assign w_restart    = w_count_zero && (r_prev_count != LP_MAX) && (r_prev_count != '0);

  // Epoch belonging to the count on the bus this cycle; also the next value of r_wraps.
  always_comb begin
    w_epoch = r_wraps;
    if (w_wrap_now) begin
      w_epoch = r_wraps + WRAP_WIDTH'(1);
    end else if (w_restart) begin
      w_epoch = '0;
    end
  end

  assign w_full = (r_level == LP_DEPTH);
  assign w_pop  = bus.out_valid && bus.out_ready;
  assign w_push = bus.event_valid && (!w_full || w_pop);
  assign w_drop = bus.event_valid && w_full && !w_pop;

  // Track previous count and the wrap epoch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_count <= '0;
      r_wraps      <= '0;
    end else begin
      r_prev_count <= bus.count;
      r_wraps      <= w_epoch;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_count[i] <= '0;
        r_mem_wraps[i] <= '0;
        r_mem_tag[i]   <= '0;
      end
    end else if (w_push) begin
      r_mem_count[r_wr_ptr] <= bus.count;
      r_mem_wraps[r_wr_ptr] <= w_epoch;
      r_mem_tag[r_wr_ptr]   <= bus.event_tag;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + (PTR_WIDTH + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - (PTR_WIDTH + 1)'(1);
      end
    end
  end

  // Drop accounting; clear wins over a simultaneous drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropped != 16'hFFFF) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  assign bus.out_valid = (r_level != '0);
  assign bus.out_count = r_mem_count[r_rd_ptr];
  assign bus.out_wraps = r_mem_wraps[r_rd_ptr];
  assign bus.out_tag   = r_mem_tag[r_rd_ptr];
  assign bus.level     = r_level;
  assign bus.dropped   = r_dropped;
  assign bus.overflow  = r_overflow;

endmodule
